// File: rtl/tcam_pkg.sv
// rtl/tcam_pkg.sv - shared widths, op codes and loader states for the TCAM table loader
package tcam_pkg;

    localparam int TCAM_BITS     = 8;
    localparam int TCAM_WORDS    = 16;
    localparam int TCAM_ADDR_W   = 4;
    localparam int TCAM_HOLD_TMO = 15;

    typedef enum logic [1:0] {
        OP_WRITE      = 2'd0,
        OP_INVALIDATE = 2'd1,
        OP_FLUSH      = 2'd2,
        OP_RSVD       = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOOT   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_SETTLE = 3'd5
    } state_e;

endpackage

// File: rtl/tcam_popcount.sv
// rtl/tcam_popcount.sv - combinational population count of the entry valid shadow
module tcam_popcount
    import tcam_pkg::*;
#(
    parameter int Words  = TCAM_WORDS,
    parameter int CountW = TCAM_ADDR_W + 1
) (
    input  logic [Words-1:0]  bits_in,
    output logic [CountW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < Words; i++) begin
            count = count + CountW'(bits_in[i]);
        end
    end

endmodule

// File: rtl/tcam_table_loader.sv
// rtl/tcam_table_loader.sv - TCAM table update sequencer with lookup stall and valid shadow
// Optional boot-time invalidate sweep: TCAM_LOADER_BOOT_CLEAR_EN
module tcam_table_loader
    import tcam_pkg::*;
#(
    parameter int Bits        = TCAM_BITS,
    parameter int Words       = TCAM_WORDS,
    parameter int AddressSize = TCAM_ADDR_W,
    parameter int HOLD_TMO    = TCAM_HOLD_TMO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [AddressSize-1:0] cmd_addr,
    input  logic [Bits-1:0]        cmd_data,
    input  logic [Bits-1:0]        cmd_mask,
    input  logic                   lookup_busy,
    output logic                   lookup_hold,
    output logic                   tcam_cs,
    output logic                   tcam_wr,
    output logic                   tcam_flush,
    output logic                   tcam_vbe,
    output logic                   tcam_dcs,
    output logic                   tcam_vbi,
    output logic [AddressSize-1:0] tcam_a,
    output logic [Bits-1:0]        tcam_di,
    output logic [Bits-1:0]        tcam_mskb,
    output logic [Words-1:0]       entry_valid,
    output logic [AddressSize:0]   entry_count,
    output logic                   done,
    output logic                   err
);

`ifdef TCAM_LOADER_BOOT_CLEAR_EN
    localparam logic BOOT_EN = 1'b1;
`else
    localparam logic BOOT_EN = 1'b0;
`endif
    localparam state_e RESET_STATE = BOOT_EN ? ST_BOOT : ST_IDLE;
    localparam int     TMO_W       = $clog2(HOLD_TMO + 1);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [AddressSize-1:0] addr_q, addr_d;
    logic [Bits-1:0]        data_q, data_d;
    logic [Bits-1:0]        mask_q, mask_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   boot_q, boot_d;
    logic [Words-1:0]       entry_valid_q, entry_valid_d;
    logic                   err_d;

    logic                   cmd_ready_q, cmd_ready_d;
    logic                   lookup_hold_q, lookup_hold_d;
    logic                   cs_q, cs_d, wr_q, wr_d, flush_q, flush_d;
    logic                   vbe_q, vbe_d, dcs_q, dcs_d, vbi_q, vbi_d;
    logic [AddressSize-1:0] a_q, a_d;
    logic [Bits-1:0]        di_q, di_d, mskb_q, mskb_d;
    logic                   done_q, done_d, err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RESET_STATE;
            op_q          <= OP_WRITE;
            addr_q        <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            tmo_q         <= '0;
            boot_q        <= BOOT_EN;
            entry_valid_q <= '0;
            cmd_ready_q   <= ~BOOT_EN;
            lookup_hold_q <= 1'b0;
            cs_q          <= 1'b0;
            wr_q          <= 1'b0;
            flush_q       <= 1'b0;
            vbe_q         <= 1'b0;
            dcs_q         <= 1'b0;
            vbi_q         <= 1'b0;
            a_q           <= '0;
            di_q          <= '0;
            mskb_q        <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            tmo_q         <= tmo_d;
            boot_q        <= boot_d;
            entry_valid_q <= entry_valid_d;
            cmd_ready_q   <= cmd_ready_d;
            lookup_hold_q <= lookup_hold_d;
            cs_q          <= cs_d;
            wr_q          <= wr_d;
            flush_q       <= flush_d;
            vbe_q         <= vbe_d;
            dcs_q         <= dcs_d;
            vbi_q         <= vbi_d;
            a_q           <= a_d;
            di_q          <= di_d;
            mskb_q        <= mskb_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mask_d        = mask_q;
        tmo_d         = tmo_q;
        boot_d        = boot_q;
        entry_valid_d = entry_valid_q;
        err_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = op_e'(cmd_op);
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    mask_d = cmd_mask;
                    tmo_d  = '0;
                    if (op_e'(cmd_op) == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            // addr_q doubles as the sweep counter while booting
            ST_BOOT: begin
                op_d    = OP_INVALIDATE;
                data_d  = '0;
                mask_d  = '0;
                tmo_d   = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lookup_busy) begin
                    state_d = (op_q == OP_FLUSH) ? ST_FLUSH : ST_WRITE;
                end else if (tmo_q == TMO_W'(HOLD_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = boot_q ? ST_BOOT : ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WRITE: begin
                entry_valid_d[addr_q] = (op_q == OP_WRITE);
                state_d               = ST_SETTLE;
            end
            ST_FLUSH: begin
                entry_valid_d = '0;
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (boot_q) begin
                    addr_d = addr_q + AddressSize'(1);
                    if (addr_q == AddressSize'(Words - 1)) begin
                        addr_d  = '0;
                        boot_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BOOT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are decoded from the next state so every output leaves a flop
    always_comb begin
        cmd_ready_d   = (state_d == ST_IDLE);
        lookup_hold_d = (state_d == ST_HOLD) || (state_d == ST_WRITE) ||
                        (state_d == ST_FLUSH) || (state_d == ST_SETTLE);
        cs_d          = (state_d == ST_WRITE) || (state_d == ST_FLUSH);
        wr_d          = (state_d == ST_WRITE);
        vbe_d         = (state_d == ST_WRITE);
        flush_d       = (state_d == ST_FLUSH);
        dcs_d         = (state_d == ST_WRITE) && (op_d == OP_WRITE);
        vbi_d         = dcs_d;
        a_d           = (state_d == ST_WRITE) ? addr_d : '0;
        di_d          = dcs_d ? data_d : '0;
        mskb_d        = dcs_d ? mask_d : '0;
        done_d        = (state_d == ST_SETTLE) && !boot_d;
    end

    tcam_popcount #(
        .Words  (Words),
        .CountW (AddressSize + 1)
    ) u_popcount (
        .bits_in (entry_valid_q),
        .count   (entry_count)
    );

    assign cmd_ready   = cmd_ready_q;
    assign lookup_hold = lookup_hold_q;
    assign tcam_cs     = cs_q;
    assign tcam_wr     = wr_q;
    assign tcam_flush  = flush_q;
    assign tcam_vbe    = vbe_q;
    assign tcam_dcs    = dcs_q;
    assign tcam_vbi    = vbi_q;
    assign tcam_a      = a_q;
    assign tcam_di     = di_q;
    assign tcam_mskb   = mskb_q;
    assign entry_valid = entry_valid_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_tcam_table_loader.sv
// tb/tb_tcam_table_loader.sv - scoreboard bench for tcam_table_loader (default build)
module tb_tcam_table_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic [7:0]  cmd_mask = '0;
    logic        lookup_busy = 1'b0;
    logic        lookup_hold;
    logic        tcam_cs, tcam_wr, tcam_flush, tcam_vbe, tcam_dcs, tcam_vbi;
    logic [3:0]  tcam_a;
    logic [7:0]  tcam_di, tcam_mskb;
    logic [15:0] entry_valid;
    logic [4:0]  entry_count;
    logic        done, err;

    tcam_table_loader dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .lookup_busy(lookup_busy), .lookup_hold(lookup_hold),
        .tcam_cs(tcam_cs), .tcam_wr(tcam_wr), .tcam_flush(tcam_flush), .tcam_vbe(tcam_vbe),
        .tcam_dcs(tcam_dcs), .tcam_vbi(tcam_vbi), .tcam_a(tcam_a), .tcam_di(tcam_di),
        .tcam_mskb(tcam_mskb), .entry_valid(entry_valid), .entry_count(entry_count),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        int          lat;
        int          wr_cnt;
        int          flush_cnt;
        logic [3:0]  a;
        logic [7:0]  di;
        logic [7:0]  mskb;
        logic        vbi;
        logic [15:0] valid;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] model_valid;
    int          errors = 0;
    int          checks = 0;

    int          obs_lat, obs_wr_cnt, obs_flush_cnt, obs_wr_cyc;
    logic        obs_done, obs_err, obs_cs_any, obs_hold_any, obs_hold_ok, obs_vbi;
    logic [3:0]  obs_a;
    logic [7:0]  obs_di, obs_mskb;
    logic [15:0] obs_valid;
    logic [4:0]  obs_count;

    function automatic exp_t mk(input logic is_err, input int lat, input int wr_cnt, input int flush_cnt,
                                input logic [3:0] a, input logic [7:0] di, input logic [7:0] mskb,
                                input logic vbi, input logic [15:0] valid);
        exp_t x;
        x.is_err = is_err; x.lat = lat; x.wr_cnt = wr_cnt; x.flush_cnt = flush_cnt;
        x.a = a; x.di = di; x.mskb = mskb; x.vbi = vbi; x.valid = valid;
        return x;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; lookup_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_valid = '0;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                             input logic [7:0] mask, input int busy_n);
        obs_lat = -1; obs_done = 0; obs_err = 0; obs_wr_cnt = 0; obs_flush_cnt = 0; obs_wr_cyc = -1;
        obs_cs_any = 0; obs_hold_any = 0; obs_hold_ok = 1; obs_vbi = 0;
        obs_a = '0; obs_di = '0; obs_mskb = '0; obs_valid = '0; obs_count = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
        lookup_busy = (busy_n > 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            lookup_busy = (cyc <= busy_n);
            @(negedge clk);
            if (tcam_cs) obs_cs_any = 1;
            if (lookup_hold) obs_hold_any = 1;
            if (tcam_wr) begin
                obs_wr_cnt++; obs_wr_cyc = cyc;
                obs_a = tcam_a; obs_di = tcam_di; obs_mskb = tcam_mskb; obs_vbi = tcam_vbi;
            end
            if (tcam_flush) obs_flush_cnt++;
            if (done || err) begin
                obs_done = done; obs_err = err; obs_lat = cyc;
                obs_valid = entry_valid; obs_count = entry_count;
                break;
            end
            if (!lookup_hold) obs_hold_ok = 0;
            @(posedge clk); #1;
        end
        lookup_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({tcam_cs, tcam_wr, tcam_flush, tcam_vbe, tcam_dcs, tcam_vbi, tcam_a, tcam_di, tcam_mskb,
             lookup_hold, done, err} !== '0) begin
            errors++; $display("FAIL reset_pins got cs=%b wr=%b fl=%b a=%h di=%h hold=%b done=%b err=%b exp all 0",
                               tcam_cs, tcam_wr, tcam_flush, tcam_a, tcam_di, lookup_hold, done, err);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++;
        if (entry_valid !== 16'h0 || entry_count !== 5'd0) begin
            errors++; $display("FAIL reset_shadow got valid=%h count=%0d exp 0/0", entry_valid, entry_count);
        end
    endtask

    task automatic test_write();
        model_valid[3] = 1'b1;
        sb.push_back(mk(0, 3, 1, 0, 4'd3, 8'hA0, 8'hF0, 1'b1, model_valid));
        drive_cmd(2'd0, 4'd3, 8'hA0, 8'hF0, 0);
        e = sb.pop_front();
        checks++;
        if (obs_done !== 1'b1 || obs_err !== e.is_err || obs_lat != e.lat) begin
            errors++; $display("FAIL write_done got done=%b err=%b lat=%0d exp done=1 err=0 lat=%0d", obs_done, obs_err, obs_lat, e.lat);
        end
        checks++;
        if (obs_wr_cyc != 2 || obs_a !== e.a || obs_di !== e.di || obs_mskb !== e.mskb || obs_vbi !== e.vbi) begin
            errors++; $display("FAIL write_pins got cyc=%0d a=%h di=%h mskb=%h vbi=%b exp cyc=2 a=%h di=%h mskb=%h vbi=%b",
                               obs_wr_cyc, obs_a, obs_di, obs_mskb, obs_vbi, e.a, e.di, e.mskb, e.vbi);
        end
        checks++;
        if (obs_valid !== e.valid || obs_count !== 5'd1) begin
            errors++; $display("FAIL write_shadow got valid=%h count=%0d exp valid=%h count=1", obs_valid, obs_count, e.valid);
        end
    endtask

    task automatic test_busy_delay();
        model_valid[7] = 1'b1;
        sb.push_back(mk(0, 8, 1, 0, 4'd7, 8'h3C, 8'hFF, 1'b1, model_valid));
        drive_cmd(2'd0, 4'd7, 8'h3C, 8'hFF, 5);
        e = sb.pop_front();
        checks++;
        if (obs_wr_cyc != 7 || obs_lat != e.lat || obs_err !== 1'b0) begin
            errors++; $display("FAIL busy_delay got wr_cyc=%0d lat=%0d err=%b exp wr_cyc=7 lat=%0d err=0", obs_wr_cyc, obs_lat, obs_err, e.lat);
        end
        checks++;
        if (obs_hold_ok !== 1'b1 || obs_valid !== e.valid) begin
            errors++; $display("FAIL busy_hold got hold_ok=%b valid=%h exp hold_ok=1 valid=%h", obs_hold_ok, obs_valid, e.valid);
        end
    endtask

    task automatic test_timeout();
        sb.push_back(mk(1, 16, 0, 0, 4'd0, 8'h0, 8'h0, 1'b0, model_valid));
        drive_cmd(2'd0, 4'd9, 8'h55, 8'hFF, 1000);
        e = sb.pop_front();
        checks++;
        if (obs_err !== 1'b1 || obs_done !== 1'b0 || obs_lat != e.lat) begin
            errors++; $display("FAIL timeout_err got err=%b done=%b lat=%0d exp err=1 done=0 lat=%0d", obs_err, obs_done, obs_lat, e.lat);
        end
        checks++;
        if (obs_wr_cnt != 0 || obs_flush_cnt != 0 || obs_valid !== e.valid) begin
            errors++; $display("FAIL timeout_noaccess got wr=%0d fl=%0d valid=%h exp 0/0 valid=%h", obs_wr_cnt, obs_flush_cnt, obs_valid, e.valid);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            logic [3:0] ad;
            ad = (i == 0) ? 4'd0 : (i == 1) ? 4'd5 : 4'd15;
            model_valid[ad] = 1'b1;
            sb.push_back(mk(0, 3, 1, 0, ad, 8'h10 + 8'(i), 8'hFF, 1'b1, model_valid));
            drive_cmd(2'd0, ad, 8'h10 + 8'(i), 8'hFF, 0);
            e = sb.pop_front();
            checks++;
            if (obs_valid !== e.valid || obs_a !== e.a || obs_done !== 1'b1) begin
                errors++; $display("FAIL flush_prefill got valid=%h a=%h done=%b exp valid=%h a=%h done=1", obs_valid, obs_a, obs_done, e.valid, e.a);
            end
        end
        checks++;
        if (entry_count !== 5'd3) begin errors++; $display("FAIL flush_precount got=%0d exp=3", entry_count); end
        model_valid = '0;
        sb.push_back(mk(0, 3, 0, 1, 4'd0, 8'h0, 8'h0, 1'b0, model_valid));
        drive_cmd(2'd2, 4'd0, 8'h0, 8'h0, 0);
        e = sb.pop_front();
        checks++;
        if (obs_flush_cnt != e.flush_cnt || obs_wr_cnt != e.wr_cnt || obs_lat != e.lat || obs_valid !== e.valid || obs_count !== 5'd0) begin
            errors++; $display("FAIL flush_op got fl=%0d wr=%0d lat=%0d valid=%h count=%0d exp fl=1 wr=0 lat=3 valid=0 count=0",
                               obs_flush_cnt, obs_wr_cnt, obs_lat, obs_valid, obs_count);
        end
        sb.push_back(mk(0, 3, 1, 0, 4'd5, 8'h0, 8'h0, 1'b0, model_valid));
        drive_cmd(2'd1, 4'd5, 8'hEE, 8'hEE, 0);
        e = sb.pop_front();
        checks++;
        if (obs_done !== 1'b1 || obs_err !== 1'b0 || obs_vbi !== e.vbi || obs_di !== e.di || obs_a !== e.a || obs_count !== 5'd0) begin
            errors++; $display("FAIL inval_invalid got done=%b err=%b vbi=%b di=%h a=%h count=%0d exp done=1 err=0 vbi=0 di=0 a=5 count=0",
                               obs_done, obs_err, obs_vbi, obs_di, obs_a, obs_count);
        end
    endtask

    task automatic test_rewrite();
        model_valid[2] = 1'b1;
        drive_cmd(2'd0, 4'd2, 8'h11, 8'h0F, 0);
        sb.push_back(mk(0, 3, 1, 0, 4'd2, 8'h22, 8'hF0, 1'b1, model_valid));
        drive_cmd(2'd0, 4'd2, 8'h22, 8'hF0, 0);
        e = sb.pop_front();
        checks++;
        if (obs_di !== e.di || obs_mskb !== e.mskb || obs_valid !== e.valid || obs_count !== 5'd1) begin
            errors++; $display("FAIL rewrite got di=%h mskb=%h valid=%h count=%0d exp di=%h mskb=%h valid=%h count=1",
                               obs_di, obs_mskb, obs_valid, obs_count, e.di, e.mskb, e.valid);
        end
    endtask

    task automatic test_reserved();
        sb.push_back(mk(1, 1, 0, 0, 4'd0, 8'h0, 8'h0, 1'b0, model_valid));
        drive_cmd(2'd3, 4'd4, 8'hFF, 8'hFF, 0);
        e = sb.pop_front();
        checks++;
        if (obs_err !== 1'b1 || obs_lat != e.lat || obs_hold_any !== 1'b0 || obs_cs_any !== 1'b0 || obs_valid !== e.valid) begin
            errors++; $display("FAIL reserved_op got err=%b lat=%0d hold=%b cs=%b valid=%h exp err=1 lat=1 hold=0 cs=0 valid=%h",
                               obs_err, obs_lat, obs_hold_any, obs_cs_any, obs_valid, e.valid);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reserved_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_random_ops();
        for (int n = 0; n < 8; n++) begin
            logic [1:0] op;
            logic [3:0] ad;
            logic [7:0] dt, mk_v;
            op = 2'($urandom_range(0, 1)); ad = 4'($urandom_range(0, 15));
            dt = 8'($urandom); mk_v = 8'($urandom);
            model_valid[ad] = (op == 2'd0);
            sb.push_back(mk(0, 3, 1, 0, ad, (op == 2'd0) ? dt : 8'h0, (op == 2'd0) ? mk_v : 8'h0, op == 2'd0, model_valid));
            drive_cmd(op, ad, dt, mk_v, 0);
            e = sb.pop_front();
            checks++;
            if (obs_lat != e.lat || obs_a !== e.a || obs_di !== e.di || obs_mskb !== e.mskb || obs_vbi !== e.vbi ||
                obs_valid !== e.valid || obs_count !== 5'($countones(e.valid))) begin
                errors++; $display("FAIL random_op%0d op=%0d got lat=%0d a=%h di=%h mskb=%h vbi=%b valid=%h count=%0d exp lat=3 a=%h di=%h mskb=%h vbi=%b valid=%h",
                                   n, op, obs_lat, obs_a, obs_di, obs_mskb, obs_vbi, obs_valid, obs_count, e.a, e.di, e.mskb, e.vbi, e.valid);
            end
        end
    endtask

    task automatic test_reset_in_hold();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 4'd6; cmd_data = 8'h77; cmd_mask = 8'hFF; lookup_busy = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (lookup_hold !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL hold_before_reset got hold=%b ready=%b exp hold=1 ready=0", lookup_hold, cmd_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({lookup_hold, tcam_cs, tcam_wr, tcam_flush, tcam_a, tcam_di, done, err, entry_valid} !== '0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_hold got hold=%b cs=%b wr=%b valid=%h ready=%b exp all 0 ready=1",
                               lookup_hold, tcam_cs, tcam_wr, entry_valid, cmd_ready);
        end
        lookup_busy = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (entry_valid !== 16'h0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_in_hold_dropped got valid=%h done=%b exp 0/0", entry_valid, done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_valid = '0;
        test_reset();
        test_write();
        test_busy_delay();
        test_timeout();
        test_flush();
        test_rewrite();
        test_reserved();
        test_random_ops();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
